// File: rtl/nmi_apb_resp_bridge.sv
// Responder-side bridge: one nmi request becomes one APB3/APB4 transfer,
// with an ACCESS-phase timeout and slave-error reporting back to the initiator.
module nmi_apb_resp_bridge #(
  parameter int          APB_AW      = 16,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              nmi_valid_i,
  input  logic [31:0]       nmi_addr_i,
  input  logic [31:0]       nmi_wdata_i,
  input  logic [3:0]        nmi_wstrb_i,
  output logic              nmi_ready_o,
  output logic [31:0]       nmi_rdata_o,
  output logic [APB_AW-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [31:0]       pwdata_o,
  output logic [3:0]        pstrb_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              err_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic unused_addr_hi;
  assign unused_addr_hi = ^nmi_addr_i[31:APB_AW];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (nmi_valid_i) begin
          paddr_d  = nmi_addr_i[APB_AW-1:0];
          pwdata_d = nmi_wdata_i;
          pwrite_d = |nmi_wstrb_i;
          pstrb_d  = (|nmi_wstrb_i) ? nmi_wstrb_i : 4'b0000;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          rdata_d = pwrite_q ? 32'h0 : (pslverr_i ? ERR_RDATA : prdata_i);
          err_d   = pslverr_i;
          state_d = S_RESP;
        end else if (TIMEOUT_CYC != 0) begin
          // Exit exactly when the count hits the limit, so the counter never wraps.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) begin
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign psel_o      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o   = (state_q == S_ACCESS);
  assign nmi_ready_o = (state_q == S_RESP);
  assign err_o       = (state_q == S_RESP) && err_q;
  assign nmi_rdata_o = rdata_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign pwrite_o    = pwrite_q;

endmodule

// File: tb/tb_nmi_apb_resp_bridge.sv
// Bench for nmi_apb_resp_bridge: vector table plus scoreboard of expected
// completions, with hand sequences for timeout, late pready and mid-transfer reset.
module tb_nmi_apb_resp_bridge;

  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        nmi_valid_i;
  logic [31:0] nmi_addr_i;
  logic [31:0] nmi_wdata_i;
  logic [3:0]  nmi_wstrb_i;
  logic        nmi_ready_o;
  logic [31:0] nmi_rdata_o;
  logic [15:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;
  logic        err_o;

  nmi_apb_resp_bridge #(
    .APB_AW(16), .TIMEOUT_CYC(4), .ERR_RDATA(ERR_RD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .nmi_valid_i(nmi_valid_i), .nmi_addr_i(nmi_addr_i),
    .nmi_wdata_i(nmi_wdata_i), .nmi_wstrb_i(nmi_wstrb_i),
    .nmi_ready_o(nmi_ready_o), .nmi_rdata_o(nmi_rdata_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;      // ACCESS cycles with pready low; >= 4 means never ready
    logic        slverr;
    logic [31:0] prdata;
    logic [15:0] exp_paddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  // Completion monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      if (err_o === 1'b1 && nmi_ready_o !== 1'b1)
        chk("err_without_ready", 32'(err_o), 32'(nmi_ready_o));
      if (nmi_ready_o === 1'b1) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_ready");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("nmi_rdata", nmi_rdata_o, e.rdata);
          chk("err_o", 32'(err_o), 32'(e.err));
        end
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int waits,
                              input logic slverr, input logic [31:0] prdata,
                              input logic [15:0] exp_paddr, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat, input int exp_acc);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.waits = waits;
    v.slverr = slverr; v.prdata = prdata; v.exp_paddr = exp_paddr;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_acc = exp_acc;
    return v;
  endfunction

  // Starts just after a rising edge; ends just after the edge following ready, valid low.
  task automatic do_xfer(input vec_t v, output int ready_cyc);
    int  acc;
    bit  done;
    exp_t e;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    nmi_valid_i = 1'b1;
    nmi_addr_i  = v.addr;
    nmi_wdata_i = v.wdata;
    nmi_wstrb_i = v.wstrb;
    acc = 0;
    done = 1'b0;
    ready_cyc = -1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (psel_o && !penable_o) begin
        nmi_addr_i  = ~v.addr;
        nmi_wdata_i = ~v.wdata;
        nmi_wstrb_i = ~v.wstrb;
      end else if (psel_o && penable_o) begin
        acc++;
        chk("paddr", 32'(paddr_o), 32'(v.exp_paddr));
        chk("pwrite", 32'(pwrite_o), 32'(v.wstrb != 4'b0000));
        chk("pstrb", 32'(pstrb_o), 32'(v.wstrb));
        chk("pwdata", pwdata_o, v.wdata);
        pready_i  = (acc > v.waits);
        pslverr_i = (acc > v.waits) && v.slverr;
        prdata_i  = v.prdata;
      end else if (nmi_ready_o) begin
        chk("latency", 32'(c), 32'(v.exp_lat));
        chk("access_cycles", 32'(acc), 32'(v.exp_acc));
        chk("psel_in_resp", 32'(psel_o), 32'(0));
        ready_cyc = cyc_cnt;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) fail_now("xfer_completion");
    @(posedge clk_i);
    #1;
    nmi_valid_i = 1'b0;
    nmi_wstrb_i = 4'b0000;
  endtask

  initial begin
    int rc, prev_rc;
    bit seen;

    rst_i = 1'b1;
    nmi_valid_i = 1'b0; nmi_addr_i = '0; nmi_wdata_i = '0; nmi_wstrb_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

    vecs.push_back(mk(32'h0000_1004, 32'h0,         4'b0000, 0, 1'b0, 32'h1234_5678, 16'h1004, 32'h1234_5678, 1'b0, 3, 1));
    vecs.push_back(mk(32'h0000_2000, 32'hA5A5_0F0F, 4'b0011, 2, 1'b0, 32'h5555_5555, 16'h2000, 32'h0,         1'b0, 5, 3));
    vecs.push_back(mk(32'h0000_2008, 32'h0,         4'b0000, 1, 1'b1, 32'h7777_7777, 16'h2008, ERR_RD,        1'b1, 4, 2));
    vecs.push_back(mk(32'h0000_3FFC, 32'h0,         4'b0000, 3, 1'b0, 32'hCAFE_F00D, 16'h3FFC, 32'hCAFE_F00D, 1'b0, 6, 4));
    vecs.push_back(mk(32'h0000_0010, 32'h0102_0304, 4'b1111, 0, 1'b1, 32'h0,         16'h0010, 32'h0,         1'b1, 3, 1));
    vecs.push_back(mk(32'hFFFF_ABCD, 32'h0,         4'b0000, 0, 1'b0, 32'h0BAD_C0DE, 16'hABCD, 32'h0BAD_C0DE, 1'b0, 3, 1));
    vecs.push_back(mk(32'h0000_0020, 32'h1111_2222, 4'b1000, 9, 1'b0, 32'h0,         16'h0020, ERR_RD,        1'b1, 6, 4));
    vecs.push_back(mk(32'h0000_0024, 32'h0,         4'b0000, 0, 1'b0, 32'h3C3C_A5A5, 16'h0024, 32'h3C3C_A5A5, 1'b0, 3, 1));

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_psel", 32'(psel_o), 32'(0));
    chk("rst_penable", 32'(penable_o), 32'(0));
    chk("rst_pwrite", 32'(pwrite_o), 32'(0));
    chk("rst_ready", 32'(nmi_ready_o), 32'(0));
    chk("rst_err", 32'(err_o), 32'(0));
    chk("rst_paddr", 32'(paddr_o), 32'(0));
    chk("rst_pwdata", pwdata_o, 32'h0);
    chk("rst_pstrb", 32'(pstrb_o), 32'(0));
    chk("rst_rdata", nmi_rdata_o, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Table: consecutive vectors run back to back, so ready spacing = latency + 1.
    prev_rc = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      do_xfer(vecs[i], rc);
      if (prev_rc >= 0 && rc >= 0)
        chk("ready_spacing", 32'(rc - prev_rc), 32'(vecs[i].exp_lat + 1));
      prev_rc = rc;
    end

    // Timed-out read followed by a stray pready: no further completion allowed.
    do_xfer(mk(32'h0000_0040, 32'h0, 4'b0000, 9, 1'b0, 32'h0, 16'h0040, ERR_RD, 1'b1, 6, 4), rc);
    pready_i = 1'b1;
    prdata_i = 32'h9999_9999;
    @(posedge clk_i);
    #1;
    pready_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (nmi_ready_o || psel_o) seen = 1'b1;
    end
    chk("late_pready_ignored", 32'(seen), 32'(0));

    // Reset during ACCESS abandons the transfer without a completion.
    @(posedge clk_i);
    #1;
    nmi_valid_i = 1'b1;
    nmi_addr_i  = 32'h0000_5000;
    nmi_wstrb_i = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (psel_o && penable_o) seen = 1'b1;
    end
    if (!seen) fail_now("reach_access");
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_psel", 32'(psel_o), 32'(0));
    chk("midrst_penable", 32'(penable_o), 32'(0));
    chk("midrst_ready", 32'(nmi_ready_o), 32'(0));
    chk("midrst_rdata", nmi_rdata_o, 32'h0);
    rst_i = 1'b0;
    nmi_valid_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (nmi_ready_o || psel_o) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 32'(0));
    @(posedge clk_i);
    #1;
    do_xfer(mk(32'h0000_6004, 32'h0, 4'b0000, 1, 1'b0, 32'h600D_0001, 16'h6004, 32'h600D_0001, 1'b0, 4, 2), rc);

    repeat (2) @(negedge clk_i);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
